// File: rtl/im_boot_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader.
package im_boot_loader_pkg;

    localparam int IM_DATA_W = 32;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_WORD,
        S_WRITE,
        S_DONE,
        S_ERR
    } state_t;

endpackage

// File: rtl/im_boot_loader_word_asm.sv
// Big-endian word assembler: shifts bytes in MSB-first and flags the 4th byte of a word.
module im_word_asm
    import im_boot_loader_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 shift_en,
    input  logic [7:0]           byte_in,
    output logic [IM_DATA_W-1:0] word,
    output logic                 last_byte
);

    logic [1:0] byte_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word     <= '0;
            byte_idx <= 2'd0;
        end else if (clear) begin
            byte_idx <= 2'd0;
        end else if (shift_en) begin
            word     <= {word[IM_DATA_W-9:0], byte_in};
            byte_idx <= byte_idx + 2'd1;
        end
    end

    // High in the same cycle the completing byte is shifted in.
    assign last_byte = shift_en && (byte_idx == 2'd3);

endmodule

// File: rtl/im_boot_loader.sv
// Loads a length-prefixed big-endian word image from a byte stream into instruction memory.
module im_boot_loader
    import im_boot_loader_pkg::*;
#(
    parameter int ADDR_W      = 10,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [7:0]           rx_data,
    input  logic                 rx_valid,
    output logic                 rx_ready,
    output logic                 im_we,
    output logic [ADDR_W-1:0]    im_waddr,
    output logic [IM_DATA_W-1:0] im_wdata,
    output logic                 cpu_hold,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    localparam int                IDLE_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYC - 1);
    localparam logic [16:0]       MAX_WORDS = 17'(2 ** ADDR_W);

    state_t                 state, next_state;
    logic [7:0]             len_hi;
    logic [15:0]            len;
    logic [ADDR_W-1:0]      word_cnt;
    logic [IDLE_W-1:0]      idle_cnt;
    logic [IM_DATA_W-1:0]   word;
    logic                   last_byte;
    logic                   take;
    logic                   waiting;
    logic                   timeout;
    logic                   len_bad;
    logic                   last_word;
    logic [15:0]            len_in;

    assign waiting   = (state == S_LEN_HI) || (state == S_LEN_LO) || (state == S_WORD);
    assign take      = rx_valid && waiting;
    assign len_in    = {len_hi, rx_data};
    assign len_bad   = (len_in == 16'd0) || ({1'b0, len_in} > MAX_WORDS);
    assign timeout   = waiting && !take && (idle_cnt == IDLE_LAST);
    assign last_word = (16'(word_cnt) == (len - 16'd1));

    im_word_asm u_word_asm (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (state == S_LEN_LO),
        .shift_en  ((state == S_WORD) && take),
        .byte_in   (rx_data),
        .word      (word),
        .last_byte (last_byte)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        rx_ready   = waiting;
        im_we      = 1'b0;
        im_waddr   = word_cnt;
        im_wdata   = '0;
        cpu_hold   = 1'b1;
        busy       = 1'b0;
        done       = 1'b0;
        err        = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) next_state = S_LEN_HI;
            end
            S_LEN_HI: begin
                busy = 1'b1;
                if (timeout)   next_state = S_ERR;
                else if (take) next_state = S_LEN_LO;
            end
            S_LEN_LO: begin
                busy = 1'b1;
                if (timeout)   next_state = S_ERR;
                else if (take) next_state = len_bad ? S_ERR : S_WORD;
            end
            S_WORD: begin
                busy = 1'b1;
                if (timeout)        next_state = S_ERR;
                else if (last_byte) next_state = S_WRITE;
            end
            S_WRITE: begin
                busy       = 1'b1;
                im_we      = 1'b1;
                im_wdata   = word;
                next_state = last_word ? S_DONE : S_WORD;
            end
            S_DONE: begin
                done     = 1'b1;
                cpu_hold = 1'b0;
                if (start) next_state = S_LEN_HI;
            end
            S_ERR: begin
                err = 1'b1;
                if (start) next_state = S_LEN_HI;
            end
            default: next_state = S_IDLE;
        endcase
    end

    // The idle counter restarts on every accepted byte and whenever a new load begins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_hi   <= 8'd0;
            len      <= 16'd0;
            word_cnt <= '0;
            idle_cnt <= '0;
        end else begin
            if ((state == S_LEN_HI) && take) begin
                len_hi <= rx_data;
            end
            if ((state == S_LEN_LO) && take) begin
                len      <= len_in;
                word_cnt <= '0;
            end
            if (state == S_WRITE) begin
                word_cnt <= word_cnt + ADDR_W'(1);
            end
            if (take || ((next_state == S_LEN_HI) && (state != S_LEN_HI))) begin
                idle_cnt <= '0;
            end else if (waiting) begin
                idle_cnt <= idle_cnt + IDLE_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_im_boot_loader.sv
// Directed bench for im_boot_loader: an image-level model predicts every IM write and the load outcome.
module tb_im_boot_loader;

    localparam int ADDR_W      = 10;
    localparam int TIMEOUT_CYC = 16;

    logic                clk;
    logic                rst_n;
    logic                start;
    logic [7:0]          rx_data;
    logic                rx_valid;
    logic                rx_ready;
    logic                im_we;
    logic [ADDR_W-1:0]   im_waddr;
    logic [31:0]         im_wdata;
    logic                cpu_hold;
    logic                busy;
    logic                done;
    logic                err;

    int total = 0;
    int bad   = 0;

    logic [7:0]  stim_q[$];
    logic [41:0] exp_q[$];
    logic [41:0] obs_q[$];
    logic        exp_done;
    logic        exp_err;
    int          cyc = 0;
    int          last_we_cyc = -1;
    int          done_rise_cyc = -1;
    logic        done_prev = 1'b0;

    im_boot_loader #(
        .ADDR_W      (ADDR_W),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .im_we    (im_we),
        .im_waddr (im_waddr),
        .im_wdata (im_wdata),
        .cpu_hold (cpu_hold),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [41:0] act, input logic [41:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Image-level model: parse the byte stream and list the writes it must produce.
    task automatic build_expect();
        int n;
        int avail;
        int full;
        exp_q.delete();
        n = int'({stim_q[0], stim_q[1]});
        if (n == 0 || n > (1 << ADDR_W)) begin
            exp_done = 1'b0;
            exp_err  = 1'b1;
        end else begin
            avail = (stim_q.size() - 2) / 4;
            full  = (avail < n) ? avail : n;
            for (int w = 0; w < full; w++) begin
                exp_q.push_back({10'(w), stim_q[2+4*w], stim_q[3+4*w], stim_q[4+4*w], stim_q[5+4*w]});
            end
            exp_done = (full == n);
            exp_err  = !exp_done;
        end
    endtask

    // Every IM write is checked against the model, and done-rise timing is recorded.
    initial begin
        logic [41:0] e;
        forever begin
            @(negedge clk);
            cyc++;
            if (im_we) begin
                if (exp_q.size() == 0) begin
                    checkOutput("spurious_we", {32'd0, im_waddr, im_wdata}, 42'd0);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("we_addr", 42'(im_waddr), 42'(e[41:32]));
                    checkOutput("we_data", 42'(im_wdata), 42'(e[31:0]));
                end
                checkOutput("ready_in_write", 42'(rx_ready), 42'd0);
                obs_q.push_back({im_waddr, im_wdata});
                last_we_cyc = cyc;
            end
            if (done && !done_prev) done_rise_cyc = cyc;
            done_prev = done;
        end
    end

    task automatic pulseStart();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        logic rdy;
        logic ok;
        ok       = 1'b0;
        rx_data  = b;
        rx_valid = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            rdy = rx_ready;
            @(posedge clk);
            ok = rdy;
        end
        if (!ok) checkOutput("rx_accept_timeout", 42'd0, 42'd1);
        #1 rx_valid = 1'b0;
    endtask

    task automatic applyStimulus();
        build_expect();
        obs_q.delete();
        done_rise_cyc = -1;
        last_we_cyc   = -1;
        pulseStart();
        for (int i = 0; i < stim_q.size(); i++) send_byte(stim_q[i]);
    endtask

    task automatic waitOutcome(input string name);
        for (int i = 0; i < 100 && !(done || err); i++) @(negedge clk);
        checkOutput({name, "_done"}, 42'(done), 42'(exp_done));
        checkOutput({name, "_err"}, 42'(err), 42'(exp_err));
        checkOutput({name, "_hold"}, 42'(cpu_hold), 42'(!exp_done));
        checkOutput({name, "_busy"}, 42'(busy), 42'd0);
        checkOutput({name, "_pending"}, 42'(exp_q.size()), 42'd0);
    endtask

    task automatic check_reset_values(input string name);
        checkOutput({name, "_rx_ready"}, 42'(rx_ready), 42'd0);
        checkOutput({name, "_im_we"}, 42'(im_we), 42'd0);
        checkOutput({name, "_im_waddr"}, 42'(im_waddr), 42'd0);
        checkOutput({name, "_im_wdata"}, 42'(im_wdata), 42'd0);
        checkOutput({name, "_cpu_hold"}, 42'(cpu_hold), 42'd1);
        checkOutput({name, "_busy"}, 42'(busy), 42'd0);
        checkOutput({name, "_done"}, 42'(done), 42'd0);
        checkOutput({name, "_err"}, 42'(err), 42'd0);
    endtask

    task automatic add_word(input logic [31:0] w);
        stim_q.push_back(w[31:24]);
        stim_q.push_back(w[23:16]);
        stim_q.push_back(w[15:8]);
        stim_q.push_back(w[7:0]);
    endtask

    initial begin
        int cycles;
        rst_n    = 1'b0;
        start    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        exp_done = 1'b0;
        exp_err  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_values("reset");
        @(posedge clk);
        #1 rst_n = 1'b1;

        $display("[TB] T1 two-word image");
        stim_q = '{8'h00, 8'h02, 8'h08, 8'h00, 8'h0C, 8'h05, 8'h20, 8'h11, 8'h00, 8'h01};
        applyStimulus();
        waitOutcome("t1");
        checkOutput("t1_writes", 42'(obs_q.size()), 42'd2);
        if (obs_q.size() == 2) begin
            checkOutput("t1_word0", obs_q[0], {10'h000, 32'h08000C05});
            checkOutput("t1_word1", obs_q[1], {10'h001, 32'h20110001});
        end
        checkOutput("t1_done_latency", 42'(done_rise_cyc - last_we_cyc), 42'd1);
        checkOutput("t1_done_lit", 42'(done), 42'd1);
        checkOutput("t1_hold_lit", 42'(cpu_hold), 42'd0);

        $display("[TB] T2 zero length");
        stim_q = '{8'h00, 8'h00};
        applyStimulus();
        @(negedge clk);
        checkOutput("t2_err_next", 42'(err), 42'd1);
        waitOutcome("t2");
        checkOutput("t2_writes", 42'(obs_q.size()), 42'd0);

        $display("[TB] T3 oversize length");
        stim_q = '{8'h04, 8'h01};
        applyStimulus();
        @(negedge clk);
        checkOutput("t3_err_next", 42'(err), 42'd1);
        waitOutcome("t3");
        checkOutput("t3_writes", 42'(obs_q.size()), 42'd0);

        $display("[TB] T4 stall inside word 0");
        stim_q = '{8'h00, 8'h01, 8'hAA, 8'hBB, 8'hCC};
        applyStimulus();
        cycles = 0;
        do begin
            @(posedge clk);
            cycles++;
            @(negedge clk);
        end while (!err && cycles < 100);
        checkOutput("t4_timeout_cycles", 42'(cycles), 42'd16);
        waitOutcome("t4");
        checkOutput("t4_writes", 42'(obs_q.size()), 42'd0);

        $display("[TB] T5 full-depth image");
        stim_q.delete();
        stim_q.push_back(8'h04);
        stim_q.push_back(8'h00);
        for (int i = 0; i < 1024; i++) add_word(32'h1000_0000 + 32'(i));
        applyStimulus();
        waitOutcome("t5");
        checkOutput("t5_writes", 42'(obs_q.size()), 42'd1024);
        if (obs_q.size() == 1024) begin
            checkOutput("t5_last", obs_q[1023], {10'h3FF, 32'h1000_03FF});
        end
        pulseStart();
        @(negedge clk);
        checkOutput("t5_restart_done", 42'(done), 42'd0);
        checkOutput("t5_restart_hold", 42'(cpu_hold), 42'd1);
        checkOutput("t5_restart_busy", 42'(busy), 42'd1);
        exp_q.delete();
        exp_done = 1'b0;
        exp_err  = 1'b1;
        waitOutcome("t5_len_timeout");

        $display("[TB] T6 reset mid-word 5");
        stim_q.delete();
        stim_q.push_back(8'h00);
        stim_q.push_back(8'h08);
        for (int i = 0; i < 5; i++) add_word(32'hC0DE_0000 ^ (32'(i) * 32'h0101_0101));
        stim_q.push_back(8'h5A);
        stim_q.push_back(8'hA5);
        applyStimulus();
        checkOutput("t6_writes_before_reset", 42'(obs_q.size()), 42'd5);
        checkOutput("t6_pending", 42'(exp_q.size()), 42'd0);
        checkOutput("t6_busy_before", 42'(busy), 42'd1);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 check_reset_values("t6_async");
        exp_q.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check_reset_values("t6_after");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
